minilab1_mac_top: RTL and testbench
===================================

Name: minilab1_mac_top

Overview:
- Self-contained 8x8 matrix–vector multiply engine: C[i] = sum over j of A[i][j]*B[j], for i, j = 0..7.
- An on-chip 9-word x 64-bit ROM feeds one B FIFO and eight A FIFOs, each 8 deep x 8 bits.
- Eight MAC units drain the FIFOs in lock-step.
- Top-level compute block of the minilab; results go to display/debug logic.

Parameters:
- DATA_W, 8, element width in bits.
- DEPTH, 8, FIFO depth; also the vector length and the number of rows.
- ACC_W, 24, accumulator and output width.

Ports:
- CLOCK_50  input  1  system clock; all state on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin computation; level-sensitive, sampled in IDLE.
- state  output  3  current FSM state encoding, for debug.
- allFull  output  1  high while the B FIFO and all eight A FIFOs are full.
- done  output  1  high in DONE.
- cout0..cout7  output  24 each  C[0]..C[7], unsigned.

Behaviour:
- ROM contents, addresses 0..7 = A rows 0..7; byte j of row i is readdata[8j+7:8j] = 16*i + 0x11 + j.
  - Row 0 = 0x11..0x18.
  - Row 7 = 0x81..0x88.
- ROM contents, address 8 = B; byte j = j+1 (0x01..0x08).
- ROM read latency is 1 cycle: the address is registered in MEMRD and data is valid the next cycle.
- FSM encoding and transitions:
  - IDLE = 0: go to MEMRD when start=1.
  - MEMRD = 1: present the address, wait one cycle, then go to FILLB or FILLA.
  - FILLA = 2: filling A FIFO row_cnt.
  - FILLB = 3: filling the B FIFO.
  - MAC = 4: all FIFOs popped together.
  - DRAIN = 5: wait for the accumulator to settle.
  - DONE = 6: results held.
- Flow: IDLE → MEMRD(addr 8) → FILLB → MEMRD(addr 0) → FILLA(row 0) → MEMRD(addr 1) → FILLA(row 1) → … → FILLA(row 7) → MAC → DRAIN → DONE.
- FILL states:
  - Write one byte per cycle for 8 cycles, byte 0 first.
  - The byte goes on shared datain[7:0], with wrenB (FILLB) or wrenA[row_cnt] (FILLA) held high.
  - Only one write enable is high in any cycle.
  - Writes to a full FIFO are ignored.
  - Leave the state after byte 7 is written or the target FIFO reports full.
- allFull asserts the cycle after the last A FIFO (row 7) becomes full, while B is also full.
- MAC state:
  - Pop B and all eight A FIFOs together for 8 cycles.
  - MAC i accumulates acc_i += A_i * B, as an unsigned 8x8 product zero-extended to 24 bits.
  - No overflow handling is needed; the maximum sum is below 2^19.
  - Leave for DRAIN when all A FIFOs are empty.
  - FIFO read data is registered, 1-cycle latency; the MAC enable is delayed one cycle to match.
- DRAIN: 1 cycle, then DONE.
- DONE:
  - cout0..7 = accumulators, held stable.
  - done = 1.
  - Stays until reset; start is ignored.
- FIFOs:
  - Synchronous, with full and empty flags.
  - Pop on empty is ignored; data holds.
  - Simultaneous push and pop is not required.
- Reset, asserted at any time:
  - state = IDLE.
  - All FIFOs empty; row_cnt, byte count and address = 0.
  - Accumulators and cout = 0; allFull = 0; done = 0.
  - Reset mid-FILL or mid-MAC aborts fully; the next start recomputes from scratch with identical results.
- Results must reach DONE within 6 cycles of entering state 6.
- Total run from start to DONE is under 200 cycles.

Test Plan:
- Reset, then start=1 → state 0→1→3; FILLB drives datain 0x01..0x08 with wrenB=1 for 8 consecutive cycles; the B FIFO is then full.
- After FILLB → for each row i the matching wrenA[i] is high 8 cycles with datain 16*i+0x11..16*i+0x18 in order; no other wrenA bit is high in those cycles.
- Full run → allFull rises once, then all A FIFOs become empty; done=1 and state=6.
- In DONE, outputs must read:
  - cout0=780, cout1=1356, cout2=1932, cout3=2508.
  - cout4=3084, cout5=3660, cout6=4236, cout7=4812.
- Assert rst mid-FILLA (row 3), release, start again → outputs 0 during the run; the final cout values are identical to the DONE check above.
- Hold start=1 in DONE for 20 cycles → cout unchanged, state stays 6.

Source files
------------

// File: rtl/minilab1_mac_top_if.sv
// Control/result bundle of the matrix-vector engine.
// The master side drives start; the slave side (the engine) returns status and results.
interface minilab1_mac_top_if #(
    parameter int ACC_W = 24
);
    logic             start;
    logic [2:0]       state;
    logic             allFull;
    logic             done;
    logic [ACC_W-1:0] cout0, cout1, cout2, cout3, cout4, cout5, cout6, cout7;

    modport master (
        output start,
        input  state, allFull, done,
        input  cout0, cout1, cout2, cout3, cout4, cout5, cout6, cout7
    );

    modport slave (
        input  start,
        output state, allFull, done,
        output cout0, cout1, cout2, cout3, cout4, cout5, cout6, cout7
    );
endinterface

// File: rtl/minilab1_mac_top.sv
// 8x8 matrix-vector multiply: ROM -> nine small FIFOs -> eight lock-step MACs.
// state | meaning: 0 IDLE wait start | 1 MEMRD ROM read | 2 FILLA fill A row | 3 FILLB fill B | 4 MAC pop+acc | 5 DRAIN settle | 6 DONE hold
module minilab1_mac_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wren,
    input  logic              rden,
    input  logic [DATA_W-1:0] datain,
    output logic [DATA_W-1:0] dataout,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr, rptr;
    logic [AW:0]       count;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (wren && !full)
            mem[wptr] <= datain;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            dataout <= '0;
        end else if (wren && !full) begin
            wptr  <= wptr + 1'b1;
            count <= count + 1'b1;
        end else if (rden && !empty) begin
            dataout <= mem[rptr];
            rptr    <= rptr + 1'b1;
            count   <= count - 1'b1;
        end
    end
endmodule

module minilab1_mac_top #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ACC_W  = 24
) (
    input  logic               CLOCK_50,
    input  logic               rst,
    minilab1_mac_top_if.slave  bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] MEMRD = 3'd1;
    localparam logic [2:0] FILLA = 3'd2;
    localparam logic [2:0] FILLB = 3'd3;
    localparam logic [2:0] MAC   = 3'd4;
    localparam logic [2:0] DRAIN = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;

    logic [2:0]        state;
    logic [3:0]        addr;
    logic [2:0]        row_cnt;
    logic [2:0]        byte_cnt;
    logic [63:0]       rom_data;

    logic [DATA_W-1:0] datain;
    logic              wren_b;
    logic [DEPTH-1:0]  wren_a;
    logic              rden;
    logic              pop_valid;
    logic              mac_en;
    logic              target_full;
    logic              fill_last;

    logic              b_full, b_empty;
    logic [DATA_W-1:0] b_data;
    logic [DEPTH-1:0]  a_full, a_empty;
    logic [DATA_W-1:0] a_data [DEPTH];

    logic [ACC_W-1:0]  acc    [DEPTH];
    logic [ACC_W-1:0]  cout_r [DEPTH];
    logic              all_full_r;

    // Addresses 0..7 are A rows (byte j of row i = 16i+0x11+j), address 8 is B (byte j = j+1).
    function automatic logic [63:0] rom_word(input logic [3:0] a);
        logic [63:0] w;
        w = '0;
        for (int j = 0; j < 8; j++) begin
            if (a == 4'd8)
                w[8*j +: 8] = 8'(j + 1);
            else
                w[8*j +: 8] = {a[3:0], 4'h0} + 8'h11 + 8'(j);
        end
        return w;
    endfunction

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst)
            rom_data <= '0;
        else
            rom_data <= rom_word(addr);
    end

    assign datain      = rom_data[{byte_cnt, 3'b000} +: 8];
    assign target_full = (state == FILLB) ? b_full : a_full[row_cnt];
    assign fill_last   = (byte_cnt == 3'd7) || target_full;
    assign wren_b      = (state == FILLB) && !b_full;
    assign wren_a      = ((state == FILLA) && !a_full[row_cnt]) ? (DEPTH'(1) << row_cnt) : '0;
    assign rden        = (state == MAC);
    assign pop_valid   = rden && !a_empty[0];

    minilab1_mac_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_b (
        .clk(CLOCK_50), .rst(rst), .wren(wren_b), .rden(rden), .datain(datain),
        .dataout(b_data), .full(b_full), .empty(b_empty)
    );

    for (genvar g = 0; g < DEPTH; g++) begin : g_row
        minilab1_mac_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_a (
            .clk(CLOCK_50), .rst(rst), .wren(wren_a[g]), .rden(rden), .datain(datain),
            .dataout(a_data[g]), .full(a_full[g]), .empty(a_empty[g])
        );
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr     <= '0;
            row_cnt  <= '0;
            byte_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    byte_cnt <= '0;
                    if (bus.start) begin
                        addr  <= 4'd8;
                        state <= MEMRD;
                    end
                end
                MEMRD: begin
                    byte_cnt <= '0;
                    state    <= (addr == 4'd8) ? FILLB : FILLA;
                end
                FILLB: begin
                    if (fill_last) begin
                        addr    <= 4'd0;
                        row_cnt <= '0;
                        state   <= MEMRD;
                    end else begin
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                FILLA: begin
                    if (fill_last) begin
                        if (row_cnt == 3'd7) begin
                            state <= MAC;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                            addr    <= {1'b0, row_cnt + 3'd1};
                            state   <= MEMRD;
                        end
                    end else begin
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                MAC:     if (&a_empty) state <= DRAIN;
                DRAIN:   state <= DONE;
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO read data arrives one cycle after the pop, so the MAC enable trails by one.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            mac_en     <= 1'b0;
            all_full_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                acc[i]    <= '0;
                cout_r[i] <= '0;
            end
        end else begin
            mac_en     <= pop_valid;
            all_full_r <= b_full && (&a_full);
            for (int i = 0; i < DEPTH; i++) begin
                if (mac_en)
                    acc[i] <= acc[i] + (ACC_W'(a_data[i]) * ACC_W'(b_data));
                if (state == DRAIN)
                    cout_r[i] <= acc[i];
            end
        end
    end

    assign bus.state   = state;
    assign bus.allFull = all_full_r;
    assign bus.done    = (state == DONE);
    assign bus.cout0   = cout_r[0];
    assign bus.cout1   = cout_r[1];
    assign bus.cout2   = cout_r[2];
    assign bus.cout3   = cout_r[3];
    assign bus.cout4   = cout_r[4];
    assign bus.cout5   = cout_r[5];
    assign bus.cout6   = cout_r[6];
    assign bus.cout7   = cout_r[7];
endmodule

// File: tb/tb_minilab1_mac_top.sv
// Randomized-timing bench for the matrix-vector engine against an arithmetic reference.
module tb_minilab1_mac_top;
    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;
    int   c_exp [8];
    logic [2:0] path_exp [$];

    minilab1_mac_top_if bus ();

    minilab1_mac_top dut (
        .CLOCK_50 (clk),
        .rst      (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int a_elem(int i, int j);
        return 16 * i + 17 + j;
    endfunction

    function automatic int b_elem(int j);
        return j + 1;
    endfunction

    function automatic logic [23:0] cout_at(int i);
        case (i)
            0: return bus.cout0;
            1: return bus.cout1;
            2: return bus.cout2;
            3: return bus.cout3;
            4: return bus.cout4;
            5: return bus.cout5;
            6: return bus.cout6;
            default: return bus.cout7;
        endcase
    endfunction

    task automatic check_idle_reset(input string tag);
        chk({tag, "_state"}, 32'(bus.state), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_allfull"}, 32'(bus.allFull), 0);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_cout%0d", tag, i), 32'(cout_at(i)), 0);
    endtask

    task automatic check_results(input string tag);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_cout%0d", tag, i), 32'(cout_at(i)), 32'(c_exp[i]));
    endtask

    // Expects state IDLE and start just raised; monitors the whole run to DONE.
    task automatic run_to_done(input string tag, input bit drop_start);
        int   bcnt;
        int   acnt [8];
        int   rises;
        int   cyc;
        int   row;
        bit   prev_af;
        logic [2:0] path [$];
        bcnt    = 0;
        rises   = 0;
        prev_af = 1'b0;
        foreach (acnt[i]) acnt[i] = 0;
        path.push_back(3'd0);
        for (cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (cyc == 0 && drop_start) bus.start = 1'b0;
            if (path[$] != bus.state) path.push_back(bus.state);
            if (dut.wren_b) begin
                chk({tag, "_fillb_only"}, 32'(dut.wren_a), 0);
                if (bcnt < 8) chk({tag, "_fillb_data"}, 32'(dut.datain), 32'(b_elem(bcnt)));
                bcnt++;
            end
            if (dut.wren_a != 0) begin
                row = 0;
                while (row < 8 && acnt[row] == 8) row++;
                if (row < 8) begin
                    chk({tag, "_filla_onehot"}, 32'(dut.wren_a), 32'(1) << row);
                    chk({tag, "_filla_data"}, 32'(dut.datain), 32'(a_elem(row, acnt[row])));
                    acnt[row]++;
                end else begin
                    chk({tag, "_filla_extra"}, 32'(dut.wren_a), 0);
                end
            end
            if (bus.state != 3'd6) begin
                chk({tag, "_cout_zero_run"},
                    32'(bus.cout0 | bus.cout1 | bus.cout2 | bus.cout3 |
                        bus.cout4 | bus.cout5 | bus.cout6 | bus.cout7), 0);
            end
            if (bus.allFull && !prev_af) rises++;
            prev_af = bus.allFull;
            if (bus.state == 3'd6) break;
        end
        chk({tag, "_reached_done"}, 32'(bus.state), 6);
        chk({tag, "_done_flag"}, 32'(bus.done), 1);
        chk({tag, "_under_200"}, 32'(cyc < 200), 1);
        chk({tag, "_fillb_count"}, 32'(bcnt), 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_filla_count%0d", tag, i), 32'(acnt[i]), 8);
        chk({tag, "_allfull_rises"}, 32'(rises), 1);
        chk({tag, "_a_empty"}, 32'(dut.a_empty), 32'hff);
        chk({tag, "_path_len"}, 32'(path.size()), 32'(path_exp.size()));
        for (int k = 0; k < path.size() && k < path_exp.size(); k++)
            chk($sformatf("%s_path%0d", tag, k), 32'(path[k]), 32'(path_exp[k]));
        repeat (2) @(negedge clk);
        check_results(tag);
    endtask

    initial begin
        int gap;
        int guard;
        n_total = 0;
        n_bad   = 0;
        for (int i = 0; i < 8; i++) begin
            c_exp[i] = 0;
            for (int j = 0; j < 8; j++) c_exp[i] += a_elem(i, j) * b_elem(j);
        end
        path_exp.push_back(3'd0);
        path_exp.push_back(3'd1);
        path_exp.push_back(3'd3);
        for (int r = 0; r < 8; r++) begin
            path_exp.push_back(3'd1);
            path_exp.push_back(3'd2);
        end
        path_exp.push_back(3'd4);
        path_exp.push_back(3'd5);
        path_exp.push_back(3'd6);

        rst       = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_reset("in_reset");
        rst = 1'b0;
        gap = $urandom_range(1, 6);
        repeat (gap) @(negedge clk);
        check_idle_reset("after_reset");

        bus.start = 1'b1;
        run_to_done("run1", 1'($urandom_range(0, 1)));

        bus.start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("hold_state", 32'(bus.state), 6);
            chk("hold_done", 32'(bus.done), 1);
            if (k == 19) check_results("hold");
        end

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b1;
        guard = 0;
        while (!dut.wren_a[3] && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        chk("reach_row3", 32'(dut.wren_a[3]), 1);
        bus.start = 1'b0;
        gap = $urandom_range(0, 6);
        repeat (gap) @(negedge clk);
        #($urandom_range(1, 8));
        rst = 1'b1;
        #1;
        check_idle_reset("mid_reset");
        chk("mid_reset_a_empty", 32'(dut.a_empty), 32'hff);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        gap = $urandom_range(1, 5);
        repeat (gap) @(negedge clk);
        check_idle_reset("rerun_idle");
        bus.start = 1'b1;
        run_to_done("run2", 1'($urandom_range(0, 1)));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
